parity_frame_sched: RTL

Two-requester scheduler for the serial parity encoder. Accepts 15-bit data words from two independent sources over valid/ready handshakes and arbitrates them round-robin. Shifts the granted word bit-serially through an internal parity encoder and presents the finished 16-bit frame (data plus parity in bit 15) on a valid/ready output port. It sits between the word-level producers and the parity-framed link.

---
 rtl/parity_pkg.sv | 6 +
 rtl/parity_serial_enc.sv | 14 +
 rtl/parity_frame_sched.sv | 79 +++++++
 3 files changed

// File: rtl/parity_pkg.sv
// parity_pkg: shared FSM state type and frame geometry for the parity frame scheduler
package parity_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int DATA_W_DEF = 15;
  localparam int FRAME_W = DATA_W_DEF + 1;
endpackage

// File: rtl/parity_serial_enc.sv
// parity_serial_enc: serial XOR accumulator, cleared on clr and folding din while en
module parity_serial_enc (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic din,
  output logic parity
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) parity <= 1'b0;
    else if (clr) parity <= 1'b0;
    else if (en) parity <= parity ^ din;
endmodule

// File: rtl/parity_frame_sched.sv
// parity_frame_sched: round-robin two-source scheduler feeding a serial parity encoder
module parity_frame_sched
  import parity_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter bit ODD = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              out_valid,
  output logic [DATA_W:0]   out_frame,
  output logic              out_src,
  input  logic              out_ready,
  output logic              busy
);
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] data_q;
  logic src_q, last_grant, pick1, grant, parity;
  // ready is gated by rst_n so it reads 0 while reset is held, even with a valid pending
  assign pick1 = req1_valid && (!req0_valid || !last_grant);
  assign grant = rst_n && state == IDLE && (req0_valid || req1_valid);
  assign req0_ready = grant && !pick1;
  assign req1_ready = grant && pick1;
  assign busy = state != IDLE;
  parity_serial_enc u_enc (
    .clk(clk),
    .rst_n(rst_n),
    .clr(grant),
    .en(state == SHIFT),
    .din(data_q[cnt]),
    .parity(parity)
  );
  // the final data bit is folded in directly so the frame is complete on the first DONE cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      data_q <= '0;
      src_q <= 1'b0;
      last_grant <= 1'b1;
      out_valid <= 1'b0;
      out_frame <= '0;
      out_src <= 1'b0;
    end else
      case (state)
        IDLE:
          if (grant) begin
            data_q <= pick1 ? req1_data : req0_data;
            src_q <= pick1;
            last_grant <= pick1;
            cnt <= '0;
            state <= SHIFT;
          end
        SHIFT: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= DONE;
            out_valid <= 1'b1;
            out_frame <= {parity ^ data_q[cnt] ^ ODD, data_q};
            out_src <= src_q;
          end
        end
        DONE:
          if (out_ready) begin
            out_valid <= 1'b0;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
endmodule
